bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 151 +++++++++++++++
 tb/tb_bin2bcd_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// Converts an IN_W-bit unsigned value (IN_W = 4..13) into four BCD digits
// over IN_W shift cycles. Each conversion takes IN_W+2 cycles, including
// the IDLE cycle in which the next start can be accepted.
// Optional feature: define BIN2BCD_LZB_EN to add the 'blank' output, which
// flags leading-zero digits so the 7-segment decoders can blank them.
`timescale 1ns/1ps

module bin2bcd_seq #(
  parameter int IN_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin_in,
  output logic            busy,
  output logic            done,
  output logic [3:0]      digit_0,
  output logic [3:0]      digit_1,
  output logic [3:0]      digit_2,
  output logic [3:0]      digit_3
`ifdef BIN2BCD_LZB_EN
  ,
  output logic [3:0]      blank
`endif
);

  localparam int            CW       = $clog2(IN_W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(IN_W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IN_W-1:0]      shreg_q, shreg_d;
  logic [15:0]          scratch_q, scratch_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [15:0]          digits_q, digits_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [15:0]          adj;
  logic [16+IN_W-1:0]   shifted;

  // Add 3 to each scratch nibble that is 5 or more, ahead of the shift.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] > 4'd4) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {adj, shreg_q} << 1;

  // Next-state logic; digits are registered on the edge into DONE so the
  // result is already visible while done is high.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin_in;
          scratch_d = '0;
          cnt_d     = CNT_LOAD;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted[16+IN_W-1 -: 16];
        shreg_d   = shifted[IN_W-1:0];
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d  = DONE;
          digits_d = shifted[16+IN_W-1 -: 16];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign digit_0 = digits_q[3:0];
  assign digit_1 = digits_q[7:4];
  assign digit_2 = digits_q[11:8];
  assign digit_3 = digits_q[15:12];

`ifdef BIN2BCD_LZB_EN
  logic [3:0] blank_q, blank_d;

  // Leading-zero flags follow the digits: blank[i] when digit i and all higher digits are zero.
  always_comb begin
    blank_d = blank_q;
    if (state_q == SHIFT && state_d == DONE) begin
      blank_d[3] = (digits_d[15:12] == 4'd0);
      blank_d[2] = (digits_d[15:8]  == 8'd0);
      blank_d[1] = (digits_d[15:4]  == 12'd0);
      blank_d[0] = 1'b0;
    end
  end

  // Blank register; after reset all digits read zero, so only units is shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= 4'b1110;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq (IN_W = 12).
// Define BIN2BCD_LZB_EN to also check the leading-zero blank output.
`timescale 1ns/1ps

module tb_bin2bcd_seq;

  localparam int IN_W = 12;
  localparam int LAT  = IN_W + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [IN_W-1:0] binIn = '0;
  logic            busy;
  logic            done;
  logic [3:0]      digit0, digit1, digit2, digit3;
`ifdef BIN2BCD_LZB_EN
  logic [3:0]      blank;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int rem        = 0;
  int expQ[$];
  int lastValue  = 0;
  int doneCount  = 0;
  int busyCount  = 0;
  int doneCycles[$];
  bit checkEn    = 1'b0;
  logic [15:0] gotDigits;

  bin2bcd_seq #(.IN_W(IN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (binIn),
    .busy    (busy),
    .done    (done),
    .digit_0 (digit0),
    .digit_1 (digit1),
    .digit_2 (digit2),
    .digit_3 (digit3)
`ifdef BIN2BCD_LZB_EN
    ,
    .blank   (blank)
`endif
  );

  always #5 clk = ~clk;

  assign gotDigits = {digit3, digit2, digit1, digit0};

  function automatic logic [15:0] refBcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] refBlank(input int v);
    return {v < 1000, v < 100, v < 10, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Timeline model: a start seen while idle is accepted and the block is
  // then busy for IN_W+1 cycles, with done in the last of them.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem = 0;
      expQ.delete();
      lastValue = 0;
    end else if (rem == 0) begin
      if (start) begin
        expQ.push_back(int'(binIn));
        rem = LAT;
      end
    end else begin
      rem--;
    end
  end

  always @(posedge clk) cycle++;

  // Monitor: checks handshake timing every cycle and pops the scoreboard on done.
  always @(negedge clk) begin
    if (checkEn && rst_n) begin
      checkOutput("busy", busy, rem != 0);
      checkOutput("done", done, rem == 1);
      if (busy) busyCount++;
      if (done) begin
        doneCount++;
        doneCycles.push_back(cycle);
        checkOutput("scoreboard entry present", expQ.size() > 0, 1);
        if (expQ.size() > 0) lastValue = expQ.pop_front();
        checkOutput("digit_0 range", digit0 <= 4'd9, 1);
        checkOutput("digit_1 range", digit1 <= 4'd9, 1);
        checkOutput("digit_2 range", digit2 <= 4'd9, 1);
        checkOutput("digit_3 range", digit3 <= 4'd9, 1);
        checkOutput("digits result", gotDigits, refBcd(lastValue));
      end else begin
        checkOutput("digits hold", gotDigits, refBcd(lastValue));
      end
`ifdef BIN2BCD_LZB_EN
      checkOutput("blank", blank, refBlank(lastValue));
`endif
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (rem != 0 && n < LAT + 5) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic applyStimulus(input int value, input int gap);
    binIn = IN_W'(value);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    binIn = IN_W'($urandom);
    waitIdle();
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0, d0, dc0;
    logic [3:0] blankExp [4];
    int blankVals [4];

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset digits", gotDigits, 0);
`ifdef BIN2BCD_LZB_EN
    checkOutput("reset blank", blank, 4'b1110);
`endif
    rst_n = 1'b1;
    checkEn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single conversion of 2047");
    b0 = busyCount;
    d0 = doneCount;
    applyStimulus(2047, 0);
    checkOutput("2047 busy cycles", busyCount - b0, 13);
    checkOutput("2047 done pulses", doneCount - d0, 1);
    checkOutput("2047 digits", gotDigits, 16'h2047);

    $display("[TB] back-to-back 4095 then 0 with start held");
    d0 = doneCount;
    dc0 = doneCycles.size();
    binIn = 12'd4095;
    start = 1'b1;
    @(posedge clk); #1;
    binIn = 12'd0;
    waitIdle();
    @(posedge clk); #1;
    start = 1'b0;
    binIn = IN_W'($urandom);
    waitIdle();
    checkOutput("back-to-back done pulses", doneCount - d0, 2);
    if (doneCycles.size() >= dc0 + 2)
      checkOutput("back-to-back spacing", doneCycles[dc0+1] - doneCycles[dc0], 14);
    else
      checkOutput("back-to-back pulse record", doneCycles.size() - dc0, 2);
    checkOutput("back-to-back last digits", gotDigits, 16'h0000);

    $display("[TB] repeat starts during a 999 conversion");
    d0 = doneCount;
    binIn = 12'd999;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    binIn = 12'd1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    binIn = 12'd1234;
    @(posedge clk); #1;
    start = 1'b0;
    waitIdle();
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("999 done pulses", doneCount - d0, 1);
    checkOutput("999 digits", gotDigits, 16'h0999);

    $display("[TB] reset during a 1500 conversion");
    d0 = doneCount;
    binIn = 12'd1500;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort digits", gotDigits, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (LAT + 2) begin
      @(posedge clk); #1;
    end
    checkOutput("abort done pulses", doneCount - d0, 0);
    checkOutput("abort digits after", gotDigits, 0);
    applyStimulus(1500, 0);
    checkOutput("1500 digits", gotDigits, 16'h1500);

    $display("[TB] leading-zero values");
    blankVals = '{9, 40, 305, 0};
    blankExp  = '{4'b1110, 4'b1100, 4'b1000, 4'b1110};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(blankVals[i], 1);
      checkOutput("lz digits", gotDigits, refBcd(blankVals[i]));
`ifdef BIN2BCD_LZB_EN
      checkOutput("lz blank", blank, blankExp[i]);
`endif
    end

    $display("[TB] exhaustive sweep 0..4095");
    for (int v = 0; v < 4096; v++) begin
      applyStimulus(v, 0);
    end

    $display("[TB] random values with random gaps");
    repeat (64) begin
      applyStimulus(int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)));
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
